// File: rtl/pipe_pkg.sv
// Shared constants, helpers and stage word type for the pipe_delay_line slice.
package pipe_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 3;

   // Occupancy ranges over 0..depth inclusive, hence depth+1 codes.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic [DEFAULT_WIDTH-1:0] data;
      logic                     valid;
   } stage_t;

endpackage

// File: rtl/pipe_stage.sv
// One {data, valid} pipeline register with async active-low reset,
// synchronous flush (priority) and enable.
module pipe_stage #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             flush,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic [WIDTH-1:0] data,
   output logic             valid
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data  <= RESET_VALUE;
         valid <= 1'b0;
      end else if (flush) begin
         data  <= RESET_VALUE;
         valid <= 1'b0;
      end else if (enable) begin
         data  <= load_data;
         valid <= load_valid;
      end
   end

endmodule

// File: rtl/pipe_delay_line.sv
// WIDTH x DEPTH delay line with valid tracking, stall, flush and occupancy.
// Define PIPE_DELAY_TAP_EN to export every stage on stageTaps/stageValids.
module pipe_delay_line
   import pipe_pkg::*;
#(
   parameter int               WIDTH       = DEFAULT_WIDTH,
   parameter int               DEPTH       = DEFAULT_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          flush,
   input  logic [WIDTH-1:0]              inputData,
   input  logic                          inputValid,
   output logic [WIDTH-1:0]              outputData,
   output logic                          outputValid,
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          empty
`ifdef PIPE_DELAY_TAP_EN
   ,
   output logic [DEPTH*WIDTH-1:0]        stageTaps,
   output logic [DEPTH-1:0]              stageValids
`endif
);

   localparam int CW = count_width(DEPTH);

   // Entry 0 is the pipeline input; entry gi+1 is the output of stage gi.
   logic [DEPTH:0][WIDTH-1:0] data_chain;
   logic [DEPTH:0]            valid_chain;
   logic [CW-1:0]             count_reg;
   logic [CW-1:0]             count_next;

   assign data_chain[0]  = inputData;
   assign valid_chain[0] = inputValid;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         pipe_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
         ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable),
            .flush      (flush),
            .load_data  (data_chain[gi]),
            .load_valid (valid_chain[gi]),
            .data       (data_chain[gi+1]),
            .valid      (valid_chain[gi+1])
         );
      end
   endgenerate

   // Entry and exit on the same edge cancel, so the count stays within 0..DEPTH.
   always_comb begin
      count_next = count_reg + CW'(inputValid) - CW'(valid_chain[DEPTH]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (flush) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= count_next;
      end
   end

   assign outputData  = data_chain[DEPTH];
   assign outputValid = valid_chain[DEPTH];
   assign count       = count_reg;
   assign empty       = (count_reg == '0);

`ifdef PIPE_DELAY_TAP_EN
   assign stageTaps   = data_chain[DEPTH:1];
   assign stageValids = valid_chain[DEPTH:1];
`else
   // Stage contents stay internal in the default build.
`endif

endmodule

// File: tb/tb_pipe_delay_line.sv
// Scoreboard bench for pipe_delay_line (WIDTH=8, DEPTH=3, RESET_VALUE=0):
// the driver queues expected words, a negedge monitor checks emerging words.
module tb_pipe_delay_line;

   localparam int WIDTH = 8;
   localparam int DEPTH = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic             flush;
   logic [WIDTH-1:0] inputData;
   logic             inputValid;
   logic [WIDTH-1:0] outputData;
   logic             outputValid;
   logic [1:0]       count;
   logic             empty;
`ifdef PIPE_DELAY_TAP_EN
   logic [DEPTH*WIDTH-1:0] stageTaps;
   logic [DEPTH-1:0]       stageValids;
`endif

   int total = 0;
   int bad   = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic en_edge = 1'b0;

   pipe_delay_line #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .RESET_VALUE (8'h00)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .flush       (flush),
      .inputData   (inputData),
      .inputValid  (inputValid),
      .outputData  (outputData),
      .outputValid (outputValid),
      .count       (count),
      .empty       (empty)
`ifdef PIPE_DELAY_TAP_EN
      ,
      .stageTaps   (stageTaps),
      .stageValids (stageValids)
`endif
   );

   always #5 clk = ~clk;

   // Remember whether the edge just taken shifted the pipe; a flush edge
   // discards everything in flight.
   always @(posedge clk) begin
      en_edge <= reset && enable && !flush;
      if (reset && flush) exp_q.delete();
   end

   always @(negedge clk) begin
      if (en_edge && outputValid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_unexpected: got %02h want no valid output", outputData);
         end else begin
            logic [WIDTH-1:0] w;
            w = exp_q.pop_front();
            if (outputData !== w) begin
               bad++;
               $display("FAIL scoreboard_data: got %02h want %02h", outputData, w);
            end else begin
               $display("out  data=%02h ok", outputData);
            end
         end
      end
      total++;
      if (count > 2'(DEPTH)) begin
         bad++;
         $display("FAIL count_bound: got %0d want <= %0d", count, DEPTH);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs, take the edge, and return #1 after it.
   task automatic drive(input logic en, input logic fl, input logic [7:0] d, input logic v);
      enable     = en;
      flush      = fl;
      inputData  = d;
      inputValid = v;
      if (en && !fl && v) exp_q.push_back(d);
      @(posedge clk);
      #1;
      $display("in   en=%0b fl=%0b data=%02h v=%0b -> out=%02h ov=%0b count=%0d empty=%0b",
               en, fl, d, v, outputData, outputValid, count, empty);
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; flush = 1'b0; inputData = '0; inputValid = 1'b0;
      #3;
      chk("reset_data",  32'(outputData),  32'h00);
      chk("reset_valid", 32'(outputValid), 32'h0);
      chk("reset_count", 32'(count),       32'h0);
      chk("reset_empty", 32'(empty),       32'h1);
      @(posedge clk); #1; reset = 1'b1;

      // Latency and streaming occupancy
      drive(1, 0, 8'hA1, 1); chk("lat_count1", 32'(count), 1); chk("lat_ov1", 32'(outputValid), 0);
      drive(1, 0, 8'hB2, 1); chk("lat_count2", 32'(count), 2); chk("lat_ov2", 32'(outputValid), 0);
      drive(1, 0, 8'hC3, 1); chk("lat_count3", 32'(count), 3);
      chk("lat_ov3", 32'(outputValid), 1); chk("lat_data3", 32'(outputData), 32'hA1);
      drive(1, 0, 8'hD4, 1); chk("stream_count4", 32'(count), 3);
      drive(1, 0, 8'hE5, 1); chk("stream_count5", 32'(count), 3);

      // Flush beats enable on a full pipe
      drive(1, 1, 8'hFF, 1);
      chk("flush_count", 32'(count), 0); chk("flush_empty", 32'(empty), 1);
      chk("flush_ov", 32'(outputValid), 0); chk("flush_data", 32'(outputData), 32'h00);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 8'h00, 0);
         chk("flush_drain_data", 32'(outputData), 32'h00);
         chk("flush_drain_ov", 32'(outputValid), 0);
      end
      chk("flush_drain_count", 32'(count), 0);

      // Stall
      drive(1, 0, 8'hA1, 1);
      drive(1, 0, 8'hB2, 1);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 8'h77, 1);
         chk("stall_count", 32'(count), 2);
         chk("stall_ov", 32'(outputValid), 0);
      end
      drive(1, 0, 8'hC3, 1);
      chk("resume_ov", 32'(outputValid), 1); chk("resume_data", 32'(outputData), 32'hA1);
      chk("resume_count", 32'(count), 3);
      drive(1, 0, 8'h00, 0); chk("drain_count2", 32'(count), 2);
      drive(1, 0, 8'h00, 0); chk("drain_count1", 32'(count), 1);
      drive(1, 0, 8'h00, 0); chk("drain_count0", 32'(count), 0); chk("drain_empty", 32'(empty), 1);

      // Bubbles
      drive(1, 0, 8'h11, 1); chk("bub_count1", 32'(count), 1);
      drive(1, 0, 8'h22, 0); chk("bub_count2", 32'(count), 1);
      drive(1, 0, 8'h33, 1); chk("bub_count3", 32'(count), 2); chk("bub_ov3", 32'(outputValid), 1);
      drive(1, 0, 8'h00, 0); chk("bub_count4", 32'(count), 1); chk("bub_ov4", 32'(outputValid), 0);
      drive(1, 0, 8'h00, 0); chk("bub_count5", 32'(count), 1); chk("bub_ov5", 32'(outputValid), 1);
      drive(1, 0, 8'h00, 0); chk("bub_count6", 32'(count), 0); chk("bub_ov6", 32'(outputValid), 0);

`ifdef PIPE_DELAY_TAP_EN
      drive(1, 0, 8'h11, 1);
      drive(1, 0, 8'h22, 1);
      drive(1, 0, 8'h33, 1);
      chk("tap_data",  32'(stageTaps),   32'h112233);
      chk("tap_valid", 32'(stageValids), 32'h7);
      drive(1, 1, 8'h00, 0);
      chk("tap_flush_data",  32'(stageTaps),   32'h000000);
      chk("tap_flush_valid", 32'(stageValids), 32'h0);
`endif

      // Asynchronous reset mid-stream
      drive(1, 0, 8'hA1, 1);
      drive(1, 0, 8'hB2, 1);
      drive(1, 0, 8'hC3, 1);
      enable = 1'b0;
      #1;
      reset = 1'b0;
      exp_q.delete();
      #1;
      chk("async_data",  32'(outputData),  32'h00);
      chk("async_valid", 32'(outputValid), 32'h0);
      chk("async_count", 32'(count),       32'h0);
      chk("async_empty", 32'(empty),       32'h1);
      @(posedge clk); #1; reset = 1'b1;
      drive(1, 0, 8'h00, 0); chk("post_reset_ov", 32'(outputValid), 0);

      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_delay_line.md
Name: pipe_delay_line

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline with per-stage valid tracking.
- Adds stall (enable), synchronous flush and an occupancy counter.
- Used as the generic delay/alignment element between CPU pipeline stages, for example to delay control words to match datapath latency.

Parameters:
- WIDTH, 8, data bits per stage (>=1).
- DEPTH, 3, number of register stages, equal to latency in enabled cycles (>=1).
- RESET_VALUE, 0, WIDTH-bit value loaded into every data stage on reset or flush.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  advance pipeline when 1; hold all state when 0.
- flush  input  1  synchronous clear of all valid bits and data.
- inputData  input  WIDTH  data entering stage 0.
- inputValid  input  1  qualifier for inputData.
- outputData  output  WIDTH  contents of stage DEPTH-1.
- outputValid  output  1  valid bit of stage DEPTH-1.
- count  output  $clog2(DEPTH+1)  number of stages currently holding valid data.
- empty  output  1  high when count==0.

Behaviour:
- Reset (reset==0, asynchronous): every stage data = RESET_VALUE, every valid = 0, count = 0. Outputs therefore reset to outputData=RESET_VALUE, outputValid=0, count=0, empty=1.
- Clock edge with reset==1 and flush==1: same clearing as reset, synchronously. flush has priority over enable, and inputData/inputValid are discarded that cycle.
- Clock edge with flush==0 and enable==1:
  - stage0 <= {inputData, inputValid}.
  - stage i <= stage i-1 for i=1..DEPTH-1.
  - The old stage DEPTH-1 is shifted out.
- Clock edge with flush==0 and enable==0: all stages and count hold.
- Latency: a word presented with enable held high appears on outputData exactly DEPTH rising edges later. Each cycle enable is low adds one cycle.
- Data in invalid stages still shifts (no bubble collapsing). outputData is meaningful only when outputValid==1.
- count update on an enabled edge: count_next = count + inputValid - outputValid(pre-edge).
  - Simultaneous entry and exit leaves count unchanged.
  - count never exceeds DEPTH and never underflows; the bench asserts this.
- empty and all outputs are driven directly from registers or count; there is no combinational path from inputs to outputs.
- DEPTH==1: behaves as a WIDTH-bit D flip-flop with enable, flush and valid. count is 1 bit.
- Reset asserted mid-stream: all in-flight words are lost immediately, without waiting for a clock edge.

Optional Feature:
- Macro: PIPE_DELAY_TAP_EN.
- Defined: adds output port stageTaps [DEPTH*WIDTH-1:0] and stageValids [DEPTH-1:0]. Slice i holds stage i, with stage 0 in the LSBs. They carry reset/flush values identically to the stages.
- Undefined: the ports do not exist. Core behaviour is unchanged.

Decomposition:
- Shared package pipe_pkg:
  - default WIDTH/DEPTH constants.
  - a count-width helper function based on $clog2(DEPTH+1).
  - a typedef for the {data, valid} stage struct.
- One sub-module, pipe_stage: a single WIDTH+1-bit register with async active-low reset, flush and enable. pipe_delay_line instantiates DEPTH of them in a generate loop and adds the count logic.

Test Plan (WIDTH=8, DEPTH=3, RESET_VALUE=0):
- Reset: pulse reset=0 mid-cycle with stages loaded -> outputData=0x00, outputValid=0, count=0 and empty=1 immediately, before the next edge.
- Latency: enable=1; drive 0xA1, 0xB2, 0xC3 with inputValid=1 on consecutive edges -> 0xA1 on outputData with outputValid=1 after the 3rd edge; count reads 1, 2, 3, then stays 3 while streaming.
- Stall: after loading 0xA1, 0xB2, drop enable for 4 cycles -> outputs and count (2) frozen; resume -> 0xA1 emerges one edge after re-enable.
- Flush vs enable: flush=1 and enable=1 with inputData=0xFF, inputValid=1 on a full pipe -> next cycle count=0, empty=1, all stages 0x00, and 0xFF never appears at the output.
- Bubbles: pattern valid 1,0,1 (0x11, 0x22, 0x33) -> outputValid sequence 1,0,1; count never exceeds 2; a final drain with inputValid=0 returns count to 0.
- Tap (PIPE_DELAY_TAP_EN defined): after loading 0x11, 0x22, 0x33 -> stageTaps=0x112233 (stage0=0x33 in the LSBs) and stageValids=3'b111.
